// File: rtl/sort_pkg.sv
// Shared types and widths for the sort-memory arbiter.
package sort_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, LAUNCH, SORT} arb_state_t;
    typedef enum logic {OWN_HOST, OWN_SRT} owner_t;
endpackage

// File: rtl/arb_burst_cnt.sv
// Saturating consecutive-grant counter with synchronous clear; sat flags MAX reached.
module arb_burst_cnt #(
    parameter int MAX = 8,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic sat
);
    logic [W-1:0] cnt_q, cnt_d;

    assign sat = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && !sat)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sort_mem_arbiter.sv
// Shares the single-port sort memory between the host port and the sorter, and sequences sort jobs.
// Define ARB_FAIR_EN to let host reads interleave with the sorter every MAX_BURST grants.
module sort_mem_arbiter
    import sort_pkg::*;
#(
    parameter int ADDR_W    = sort_pkg::ADDR_W,
    parameter int DATA_W    = sort_pkg::DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_start,
    output logic              job_busy,
    output logic              job_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              srt_start,
    input  logic              srt_done,
    input  logic              srt_rd,
    input  logic              srt_wr,
    input  logic [ADDR_W-1:0] srt_addr,
    input  logic [DATA_W-1:0] srt_wdata,
    output logic              srt_gnt,
    output logic [DATA_W-1:0] srt_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("MAX_BURST must be at least 1");
    end

    arb_state_t state_q, state_d;
    logic       busy_q, busy_d, done_q, done_d, start_q, start_d;
    logic       rd_pend_q, rd_pend_d;
    owner_t     owner_q, owner_d;
    logic       host_slot;

`ifdef ARB_FAIR_EN
    logic host_rd, burst_sat;
    assign host_rd = host_req & ~host_we;

    arb_burst_cnt #(.MAX(MAX_BURST)) u_burst (
        .clk (clk),
        .rst (rst),
        .clr ((state_q != SORT) | ~host_rd | host_gnt),
        .inc (srt_gnt),
        .sat (burst_sat)
    );

    // Host read takes the slot when the sorter is idle or has used up its burst.
    assign host_slot = host_rd & (burst_sat | ~(srt_rd | srt_wr));
`else
    assign host_slot = 1'b0;
`endif

    // Grants are combinational; gated by rst so nothing reaches memory during reset.
    always_comb begin
        host_gnt  = 1'b0;
        srt_gnt   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    host_gnt = host_req;
                    mem_rd   = host_req & ~host_we;
                    mem_wr   = host_req & host_we;
                end
                SORT: begin
                    if (host_slot) begin
                        host_gnt = 1'b1;
                        mem_rd   = 1'b1;
                    end else begin
                        srt_gnt   = srt_rd | srt_wr;
                        mem_wr    = srt_wr;
                        mem_rd    = srt_rd & ~srt_wr;
                        mem_addr  = srt_addr;
                        mem_wdata = srt_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        start_d   = 1'b0;
        rd_pend_d = mem_rd;
        owner_d   = owner_q;
        if (mem_rd)
            owner_d = host_gnt ? OWN_HOST : OWN_SRT;
        case (state_q)
            IDLE: if (job_start) begin
                state_d = LAUNCH;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                start_d = 1'b1;
            end
            LAUNCH: state_d = SORT;
            SORT: if (srt_done) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            owner_q   <= OWN_HOST;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            start_q   <= start_d;
            rd_pend_q <= rd_pend_d;
            owner_q   <= owner_d;
        end
    end

    assign job_busy    = busy_q;
    assign job_done    = done_q;
    assign srt_start   = start_q;
    assign host_rvalid = rd_pend_q & (owner_q == OWN_HOST);
    assign host_rdata  = mem_rdata;
    assign srt_rdata   = mem_rdata;

    a_srt_rdwr: assert property (@(posedge clk) disable iff (rst) !(srt_rd && srt_wr))
        else $error("srt_rd and srt_wr asserted together");
endmodule

// File: doc/sort_mem_arbiter.md
Name: sort_mem_arbiter

Overview:
- Owns the single-port sort memory (32 x 8) and shares it between an external host port (load/unload data) and the bubble-sort engine's controller.
- Sequences a sort job: the host loads data, pulses job_start, the block launches the sorter, locks the host out, and reports completion.
- Sits between the host interface, the sorter controller, and the Memory instance.
- Registered grants are not used; all grant arbitration is combinational from the current state and requests.

Parameters:
- ADDR_W, 5, memory address width (32 words).
- DATA_W, 8, memory word width.
- MAX_BURST, 8, consecutive sorter grants before a host read slot is forced; only used with ARB_FAIR_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- job_start  in  1  host request to begin a sort; one-cycle pulse.
- job_busy  out  1  high from job accept until sorter completion.
- job_done  out  1  sticky completion flag; cleared by the next accepted job_start.
- host_req  in  1  host memory access request.
- host_we  in  1  host write (1) or read (0).
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host_rdata valid; one-cycle pulse.
- srt_start  out  1  one-cycle launch pulse to the sorter controller.
- srt_done  in  1  sorter finished; one-cycle pulse.
- srt_rd, srt_wr  in  1 each  sorter memory read/write request.
- srt_addr  in  ADDR_W  sorter address.
- srt_wdata  in  DATA_W  sorter write data.
- srt_gnt  out  1  sorter access performed; the sorter controller stalls while low.
- srt_rdata  out  DATA_W  sorter read data (direct from mem_rdata).
- mem_rd, mem_wr  out  1 each  memory strobes.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_rd.

Behaviour:
- Reset values: state IDLE; job_busy, job_done, srt_start, host_gnt, host_rvalid, srt_gnt, mem_rd, mem_wr all 0; burst count 0; pending-read owner cleared.
- States: IDLE, LAUNCH, SORT.

IDLE:
- host_gnt = host_req.
- Memory strobes come from the host port: mem_rd = host_req & ~host_we; mem_wr = host_req & host_we.
- Sorter requests are ignored (srt_gnt = 0).
- job_start -> LAUNCH. The same cycle clears job_done and sets job_busy. A host access in that cycle is still granted.

LAUNCH:
- Lasts exactly one cycle.
- srt_start = 1; no grants are issued.
- Lets any pending host read return before the sorter starts.
- Transitions to SORT.

SORT:
- srt_gnt = srt_rd | srt_wr; memory is driven from the sorter port.
- host_gnt = 0; host requests stall until the job ends.
- srt_done -> IDLE: clear job_busy, set job_done.
- srt_done together with a sorter request: that access is still granted.

Common rules:
- job_start outside IDLE is ignored.
- srt_rd and srt_wr both high: protocol violation; the write wins and a simulation assertion fires.
- Read return: a 1-bit owner register captures who issued the granted read. host_rvalid = 1 in the following cycle only if the host owned the read. host_rdata = mem_rdata.
- Async reset mid-job aborts immediately to IDLE:
  - the pending read is dropped, with no host_rvalid;
  - memory contents are left as-is;
  - srt_start is not reissued.

Optional Feature:
- Macro: ARB_FAIR_EN.

Enabled:
- In SORT, host reads (host_req & ~host_we) are permitted.
- A burst counter counts consecutive sorter grants while a host read is pending.
- When the count reaches MAX_BURST, the next cycle grants the host read instead: srt_gnt = 0 and the sorter stalls. The counter then resets to 0.
- The counter also resets whenever no host read is pending.
- Host writes are always blocked in SORT.

Disabled:
- The host is fully locked out during SORT.
- No counter logic is generated; MAX_BURST is unused.

Decomposition:
- Package sort_pkg contains:
  - ADDR_W and DATA_W constants;
  - the arb_state_t enum {IDLE, LAUNCH, SORT};
  - the owner_t enum {OWN_HOST, OWN_SRT}.
- Sub-module arb_burst_cnt: a saturating consecutive-grant counter with clear. It is instantiated only under ARB_FAIR_EN.

Test Plan:
1. Reset with host_req=1 held -> all outputs 0 during rst. After release, the host writes 0x5A to addr 3 in IDLE: mem_wr=1, mem_addr=3, host_gnt=1 in the same cycle.
2. Host read of addr 3 -> host_rvalid=1 exactly one cycle later with host_rdata=0x5A; srt_gnt stays 0.
3. job_start in IDLE -> next cycle srt_start=1 for one cycle, job_busy=1. Then srt_rd at addr 7 gets srt_gnt=1. A host_req in SORT gets host_gnt=0 (macro off).
4. srt_done pulse in SORT -> next cycle state IDLE, job_busy=0, job_done=1. A second job_start clears job_done and relaunches.
5. ARB_FAIR_EN, MAX_BURST=8: in SORT, continuous sorter reads plus a held host read -> 8 sorter grants, then 1 host grant (srt_gnt=0 that cycle), with host_rvalid one cycle later. A host write in SORT is never granted.
6. Assert rst mid-SORT with a sorter read pending -> state IDLE, job_busy=0, job_done=0, no host_rvalid, no srt_start after release.
